// File: rtl/pixel_filter_engine.sv
// pixel_filter_engine: per-pixel RGB / gray / Sobel edge view selector with a fixed 4-cycle latency
module pixel_filter_engine #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL
);
    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SW = DATA_W + 4;
    localparam logic [DATA_W-1:0] MAXV = '1;

    logic [CW-1:0]        col_q, col_d, pcol, col1_q;
    logic [1:0]           row_q, row_d, prow, row1_q;
    logic                 wrap;
    logic [DATA_W+1:0]    sum1;
    logic                 v1_q, v2_q, v3_q, dval_q;
    logic [DATA_W-1:0]    r1_q, g1_q, b1_q, gray1_q;
    logic [DATA_W-1:0]    r2_q, g2_q, b2_q, gray2_q;
    logic [DATA_W-1:0]    r3_q, g3_q, b3_q, gray3_q;
    logic [1:0]           mode1_q, mode2_q, mode3_q;
    logic                 inner2_q, inner3_q;
    logic [DATA_W-1:0]    lb0_q [0:LINE_W-1];
    logic [DATA_W-1:0]    lb1_q [0:LINE_W-1];
    logic [DATA_W-1:0]    win_q [0:2][0:2];
    logic signed [SW-1:0] p [0:2][0:2];
    logic signed [SW-1:0] gx_d, gy_d, gx3_q, gy3_q;
    logic [SW-1:0]        ax, ay, sum4;
    logic [DATA_W-1:0]    mag, edg, mono;
    logic [DATA_W-1:0]    red_q, green_q, blue_q, red_d, green_d, blue_d;

    // Position of the incoming pixel (SOF forces 0,0), next counter state and S1 gray sum
    always_comb begin
        pcol  = iSOF ? '0 : col_q;
        prow  = iSOF ? 2'd0 : row_q;
        wrap  = pcol == CW'(LINE_W - 1);
        col_d = iDVAL ? (wrap ? '0 : pcol + CW'(1)) : pcol;
        row_d = (iDVAL && wrap && prow != 2'd2) ? prow + 2'd1 : prow;
        sum1  = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    end

    // Control state: position counters, valid pipeline and held output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col_q   <= '0;
            row_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            dval_q  <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            v1_q   <= iDVAL;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            dval_q <= v3_q;
            if (v3_q) begin
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    // Data travelling alongside the valid bits; qualified downstream by those bits
    always_ff @(posedge iCLK) begin
        r1_q     <= iRed;
        g1_q     <= iGreen;
        b1_q     <= iBlue;
        gray1_q  <= DATA_W'(sum1 >> 2);
        mode1_q  <= iMODE;
        col1_q   <= pcol;
        row1_q   <= prow;
        r2_q     <= r1_q;
        g2_q     <= g1_q;
        b2_q     <= b1_q;
        gray2_q  <= gray1_q;
        mode2_q  <= mode1_q;
        inner2_q <= (row1_q == 2'd2) && (col1_q >= CW'(2));
        r3_q     <= r2_q;
        g3_q     <= g2_q;
        b3_q     <= b2_q;
        gray3_q  <= gray2_q;
        mode3_q  <= mode2_q;
        inner3_q <= inner2_q;
        gx3_q    <= gx_d;
        gy3_q    <= gy_d;
    end

    // Two-line gray history: line 0 holds the previous row, line 1 the row before it
    always_ff @(posedge iCLK) begin
        if (v1_q) begin
            lb0_q[col1_q] <= gray1_q;
            lb1_q[col1_q] <= lb0_q[col1_q];
        end
    end

    // 3x3 window shifts left one column per valid pixel; bubbles leave it untouched
    always_ff @(posedge iCLK) begin
        if (v1_q) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col1_q];
            win_q[1][2] <= lb0_q[col1_q];
            win_q[2][2] <= gray1_q;
        end
    end

    // Sobel gradients over the window (row 0 oldest line, column 2 newest pixel)
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = $signed({4'b0000, win_q[r][c]});
        gx_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
        gy_d = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    end

    // Saturated, border-masked magnitude and the per-pixel view selection
    always_comb begin
        ax      = gx3_q[SW-1] ? SW'(-gx3_q) : SW'(gx3_q);
        ay      = gy3_q[SW-1] ? SW'(-gy3_q) : SW'(gy3_q);
        sum4    = ax + ay;
        mag     = !inner3_q ? '0 : (sum4 > SW'(MAXV)) ? MAXV : sum4[DATA_W-1:0];
        edg     = (mag >= iTHRESH) ? MAXV : '0;
        mono    = (mode3_q == 2'd1) ? gray3_q : (mode3_q == 2'd2) ? edg : mag;
        red_d   = (mode3_q == 2'd0) ? r3_q : mono;
        green_d = (mode3_q == 2'd0) ? g3_q : mono;
        blue_d  = (mode3_q == 2'd0) ? b3_q : mono;
    end

    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;
    assign oDVAL  = dval_q;
endmodule

// File: tb/tb_pixel_filter_engine.sv
// tb_pixel_filter_engine: directed stimulus checked against an image-level Sobel model
module tb_pixel_filter_engine;
    localparam int W = 12;
    localparam int L = 8;
    localparam logic [W-1:0] MX = '1;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] g;
        logic [W-1:0] b;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] r_i = '0, g_i = '0, b_i = '0, th_i = '0;
    logic dv_i = 1'b0, sof_i = 1'b0;
    logic [1:0] mode_i = '0;
    logic [W-1:0] r_o, g_o, b_o;
    logic dv_o;

    exp_t q[$];
    logic [W-1:0] got_r[$], got_g[$], got_b[$];
    logic [W-1:0] last_r = '0, last_g = '0, last_b = '0;
    logic [W-1:0] img [0:63][0:L-1];
    int checks = 0, errors = 0, cyc = 0, mrow = 0, mcol = 0;

    pixel_filter_engine #(.DATA_W(W), .LINE_W(L)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iRed(r_i), .iGreen(g_i), .iBlue(b_i),
        .iDVAL(dv_i), .iSOF(sof_i), .iMODE(mode_i), .iTHRESH(th_i),
        .oRed(r_o), .oGreen(g_o), .oBlue(b_o), .oDVAL(dv_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Every cycle out of reset: either the due pixel appears, or outputs hold with oDVAL low
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (q.size() != 0 && q[0].due == cyc) begin
                got_r.push_back(r_o);
                got_g.push_back(g_o);
                got_b.push_back(b_o);
                if (dv_o !== 1'b1 || r_o !== q[0].r || g_o !== q[0].g || b_o !== q[0].b) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got dval=%b rgb=%h/%h/%h expected dval=1 rgb=%h/%h/%h",
                             cyc, dv_o, r_o, g_o, b_o, q[0].r, q[0].g, q[0].b);
                end
                last_r = q[0].r;
                last_g = q[0].g;
                last_b = q[0].b;
                q.delete(0);
            end else if (dv_o !== 1'b0 || r_o !== last_r || g_o !== last_g || b_o !== last_b) begin
                errors++;
                $display("FAIL idle cyc=%0d got dval=%b rgb=%h/%h/%h expected dval=0 rgb=%h/%h/%h",
                         cyc, dv_o, r_o, g_o, b_o, last_r, last_g, last_b);
            end
        end
    end

    task automatic pix(input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b,
                       input logic [1:0] m, input logic sof);
        int gx, gy, mag, wt, rr, cc;
        logic [W-1:0] gray, mono;
        exp_t e;
        @(posedge clk);
        #1;
        r_i = r; g_i = g; b_i = b; mode_i = m; sof_i = sof; dv_i = 1'b1;
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        rr = mrow % 64;
        cc = mcol;
        gray = W'((int'(r) + 2 * int'(g) + int'(b)) / 4);
        img[rr][cc] = gray;
        mag = 0;
        if (mrow >= 2 && mcol >= 2) begin
            gx = 0;
            gy = 0;
            for (int k = 0; k < 3; k++) begin
                wt = (k == 1) ? 2 : 1;
                gx += wt * (int'(img[(mrow - 2 + k) % 64][cc]) - int'(img[(mrow - 2 + k) % 64][cc - 2]));
                gy += wt * (int'(img[rr][cc - 2 + k]) - int'(img[(mrow - 2) % 64][cc - 2 + k]));
            end
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (mag > int'(MX)) mag = int'(MX);
        end
        mono = (m == 2'd1) ? gray : (m == 2'd2) ? ((W'(mag) >= th_i) ? MX : '0) : W'(mag);
        e.r = (m == 2'd0) ? r : mono;
        e.g = (m == 2'd0) ? g : mono;
        e.b = (m == 2'd0) ? b : mono;
        e.due = cyc + 4;
        q.push_back(e);
        mcol++;
        if (mcol == L) begin
            mcol = 0;
            mrow++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dv_i = 1'b0;
            sof_i = 1'b0;
        end
    endtask

    task automatic px(input int c, input logic [1:0] m, input logic [W-1:0] lo, input logic [W-1:0] hi,
                      input logic sof, input int gap);
        logic [W-1:0] v;
        v = (c >= 4) ? hi : lo;
        pix(v, v, v, m, sof);
        if (gap > 0) idle(gap);
    endtask

    task automatic frame(input logic [1:0] m, input logic [W-1:0] lo, input logic [W-1:0] hi, input int gap);
        for (int i = 0; i < 4 * L; i++) px(i % L, m, lo, hi, i == 0, gap);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic clr();
        got_r.delete();
        got_g.delete();
        got_b.delete();
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gr(input int i);
        return (i < got_r.size()) ? got_r[i] : 12'hBAD;
    endfunction
    function automatic logic [W-1:0] gg(input int i);
        return (i < got_g.size()) ? got_g[i] : 12'hBAD;
    endfunction
    function automatic logic [W-1:0] gb(input int i);
        return (i < got_b.size()) ? got_b[i] : 12'hBAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #1;
        chk("reset_red", r_o, '0);
        chk("reset_dval", W'(dv_o), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        clr();
        pix(12'h123, 12'h456, 12'h789, 2'd0, 1'b1);
        drain();
        chk("m0_red", gr(0), 12'h123);
        chk("m0_green", gg(0), 12'h456);
        chk("m0_blue", gb(0), 12'h789);

        clr();
        pix(12'h100, 12'h200, 12'h300, 2'd1, 1'b0);
        pix(MX, MX, MX, 2'd1, 1'b0);
        drain();
        chk("m1_gray_red", gr(0), 12'h200);
        chk("m1_gray_blue", gb(0), 12'h200);
        chk("m1_full", gr(1), 12'hFFF);

        clr();
        frame(2'd3, 12'h400, 12'h400, 0);
        drain();
        chk("m3_flat", gr(3 * L + 5), 12'h000);

        clr();
        frame(2'd3, 12'h000, MX, 0);
        drain();
        chk("m3_step_row1", gr(L + 4), 12'h000);
        chk("m3_step_c3", gr(2 * L + 3), 12'h000);
        chk("m3_step_c4", gr(2 * L + 4), 12'hFFF);
        chk("m3_step_c5", gr(2 * L + 5), 12'hFFF);
        chk("m3_step_c6", gr(2 * L + 6), 12'h000);

        th_i = 12'h100;
        clr();
        frame(2'd2, 12'h000, 12'h010, 0);
        drain();
        chk("m2_low_step", gr(2 * L + 4), 12'h000);
        clr();
        frame(2'd2, 12'h000, 12'h080, 0);
        drain();
        chk("m2_high_step", gr(2 * L + 4), 12'hFFF);
        chk("m2_high_border", gr(L + 4), 12'h000);
        chk("m2_high_flat", gr(2 * L + 6), 12'h000);

        clr();
        frame(2'd3, 12'h000, MX, 10);
        drain();
        chk("gap_c4", gr(2 * L + 4), 12'hFFF);
        chk("gap_c5", gr(2 * L + 5), 12'hFFF);
        chk("gap_c6", gr(2 * L + 6), 12'h000);

        clr();
        for (int i = 0; i < 3 * L + 5; i++) px(i % L, 2'd3, 12'h000, MX, i == 0, 0);
        for (int i = 0; i < 3 * L; i++) px(i % L, 2'd3, 12'h000, MX, i == 0, 0);
        drain();
        chk("sof_row0", gr(3 * L + 5 + 4), 12'h000);
        chk("sof_row1", gr(3 * L + 5 + L + 5), 12'h000);
        chk("sof_row2", gr(3 * L + 5 + 2 * L + 4), 12'hFFF);

        clr();
        for (int c = 0; c < L; c++) pix(12'h100, 12'h200, 12'h300, (c < 4) ? 2'd0 : 2'd1, c == 0);
        drain();
        chk("switch_last_rgb", gr(3), 12'h100);
        chk("switch_last_blue", gb(3), 12'h300);
        chk("switch_first_gray", gr(4), 12'h200);
        chk("switch_first_blue", gb(4), 12'h200);

        for (int i = 0; i < 6; i++) pix(12'h321, 12'h654, 12'h987, 2'd0, i == 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_red", r_o, '0);
        chk("async_green", g_o, '0);
        chk("async_dval", W'(dv_o), '0);
        q.delete();
        last_r = '0; last_g = '0; last_b = '0;
        mrow = 0; mcol = 0;
        @(posedge clk);
        #1 dv_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        for (int i = 0; i < 4 * L; i++) px(i % L, 2'd3, 12'h000, MX, 1'b0, 0);
        drain();
        chk("post_reset_row1", gr(L + 4), 12'h000);
        chk("post_reset_c4", gr(2 * L + 4), 12'hFFF);
        chk("post_reset_c6", gr(2 * L + 6), 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
